// File: rtl/rx_phy_deframer.sv
`default_nettype none
// ============================================================================
// Module   : rx_phy_deframer
// Purpose  : Drains the 4-bit receive FIFO fed by clock/data recovery, hunts
//            for the 802.15.4 synchronisation header (zero-nibble preamble and
//            SFD 0xA7), extracts the 7-bit PHR length and delivers the payload
//            as a qualified nibble stream with start/end markers. Sync, length
//            and inactivity-timeout errors are reported as one-cycle pulses.
// Ports    : inClock/inReset     - clock, asynchronous active-high reset
//            inEnable            - permits new FIFO reads
//            inEmpty/inData      - FIFO empty flag and read data (1-cycle lat.)
//            outReadEnable       - FIFO read strobe
//            outNibble/Valid     - payload nibble and its qualifier
//            outFrameStart/End   - first/last payload nibble markers
//            outLength           - PHR length (bytes) of current/last frame
//            outSyncError/outLengthError/outAbort - error pulses
//            outBusy             - high whenever a frame is being parsed
// Revision : 1.0 - initial release
// ============================================================================
module rx_phy_deframer #(
    parameter int PREAMBLE_NIBBLES = 8,
    parameter int MAX_LEN          = 127,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inEnable,
    input  logic       inEmpty,
    input  logic [3:0] inData,
    output logic       outReadEnable,
    output logic [3:0] outNibble,
    output logic       outNibbleValid,
    output logic       outFrameStart,
    output logic       outFrameEnd,
    output logic [6:0] outLength,
    output logic       outSyncError,
    output logic       outLengthError,
    output logic       outAbort,
    output logic       outBusy
);

    localparam int c_ZC_W = $clog2(PREAMBLE_NIBBLES + 1);
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_ZC_W-1:0] c_ZC_LAST = c_ZC_W'(PREAMBLE_NIBBLES - 1);
    localparam logic [c_ZC_W-1:0] c_ZC_FULL = c_ZC_W'(PREAMBLE_NIBBLES);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        c_MAX_LEN = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_SFD_LO  = 3'd1,
        S_SFD_HI  = 3'd2,
        S_LEN_LO  = 3'd3,
        S_LEN_HI  = 3'd4,
        S_PAYLOAD = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [c_ZC_W-1:0]   zeroCnt_q, zeroCnt_d;
    logic [c_TO_W-1:0]   timeout_q, timeout_d;
    logic                rdPending_q;
    logic [3:0]          lenLow_q, lenLow_d;
    logic [7:0]          remain_q, remain_d;
    logic [6:0]          length_q, length_d;
    logic [3:0]          nibble_q, nibble_d;
    logic                nibbleValid_q, nibbleValid_d;
    logic                frameStart_q, frameStart_d;
    logic                frameEnd_q, frameEnd_d;
    logic                syncErr_q, syncErr_d;
    logic                lenErr_q, lenErr_d;
    logic                abort_q, abort_d;
    logic                busy_q, busy_d;

    logic                consume;
    logic [6:0]          phrLen;
    logic                firstNibble;

    // Reset gates the strobe so no FIFO entry is lost while the parser is held.
    assign outReadEnable = inEnable & ~inEmpty & ~inReset;

    // Read data is valid the cycle after the strobe, so the registered strobe
    // marks the cycle in which inData holds a fresh nibble.
    assign consume = rdPending_q;

    // PHR bit 7 is reserved; only the three low bits of the high nibble count.
    assign phrLen = {inData[2:0], lenLow_q};

    // The remaining count still equals twice the length only before the
    // first payload nibble has been taken.
    assign firstNibble = (remain_q == {length_q, 1'b0});

    always_comb begin
        state_d       = state_q;
        zeroCnt_d     = zeroCnt_q;
        timeout_d     = timeout_q;
        lenLow_d      = lenLow_q;
        remain_d      = remain_q;
        length_d      = length_q;
        nibble_d      = nibble_q;
        nibbleValid_d = 1'b0;
        frameStart_d  = 1'b0;
        frameEnd_d    = 1'b0;
        syncErr_d     = 1'b0;
        lenErr_d      = 1'b0;
        abort_d       = 1'b0;
        busy_d        = (state_q != S_HUNT);

        // Inactivity watchdog: only meaningful once a header is in progress.
        // An abort can only fire on an idle cycle, so it never lines up with
        // a nibble or another error pulse.
        if (state_q == S_HUNT || consume) begin
            timeout_d = '0;
        end else if (timeout_q == c_TO_LAST) begin
            abort_d   = 1'b1;
            state_d   = S_HUNT;
            zeroCnt_d = '0;
            timeout_d = '0;
            remain_d  = '0;
        end else begin
            timeout_d = timeout_q + c_TO_W'(1);
        end

        if (consume) begin
            unique case (state_q)
                S_HUNT: begin
                    if (inData == 4'h0) begin
                        if (zeroCnt_q == c_ZC_LAST) begin
                            zeroCnt_d = c_ZC_FULL;
                            state_d   = S_SFD_LO;
                        end else begin
                            zeroCnt_d = zeroCnt_q + c_ZC_W'(1);
                        end
                    end else begin
                        zeroCnt_d = '0;
                    end
                end
                S_SFD_LO: begin
                    // Extra preamble zeros are tolerated here.
                    if (inData == 4'h7) begin
                        state_d = S_SFD_HI;
                    end else if (inData != 4'h0) begin
                        syncErr_d = 1'b1;
                        state_d   = S_HUNT;
                        zeroCnt_d = '0;
                    end
                end
                S_SFD_HI: begin
                    if (inData == 4'hA) begin
                        state_d = S_LEN_LO;
                    end else begin
                        syncErr_d = 1'b1;
                        state_d   = S_HUNT;
                        zeroCnt_d = '0;
                    end
                end
                S_LEN_LO: begin
                    lenLow_d = inData;
                    state_d  = S_LEN_HI;
                end
                S_LEN_HI: begin
                    if (phrLen == 7'd0 || {1'b0, phrLen} > c_MAX_LEN) begin
                        lenErr_d  = 1'b1;
                        state_d   = S_HUNT;
                        zeroCnt_d = '0;
                    end else begin
                        length_d = phrLen;
                        remain_d = {phrLen, 1'b0};
                        state_d  = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    nibble_d      = inData;
                    nibbleValid_d = 1'b1;
                    frameStart_d  = firstNibble;
                    remain_d      = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        frameEnd_d = 1'b1;
                        state_d    = S_HUNT;
                        zeroCnt_d  = '0;
                    end
                end
                default: begin
                    state_d   = S_HUNT;
                    zeroCnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            state_q       <= S_HUNT;
            zeroCnt_q     <= '0;
            timeout_q     <= '0;
            rdPending_q   <= 1'b0;
            lenLow_q      <= '0;
            remain_q      <= '0;
            length_q      <= '0;
            nibble_q      <= '0;
            nibbleValid_q <= 1'b0;
            frameStart_q  <= 1'b0;
            frameEnd_q    <= 1'b0;
            syncErr_q     <= 1'b0;
            lenErr_q      <= 1'b0;
            abort_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            zeroCnt_q     <= zeroCnt_d;
            timeout_q     <= timeout_d;
            rdPending_q   <= outReadEnable;
            lenLow_q      <= lenLow_d;
            remain_q      <= remain_d;
            length_q      <= length_d;
            nibble_q      <= nibble_d;
            nibbleValid_q <= nibbleValid_d;
            frameStart_q  <= frameStart_d;
            frameEnd_q    <= frameEnd_d;
            syncErr_q     <= syncErr_d;
            lenErr_q      <= lenErr_d;
            abort_q       <= abort_d;
            busy_q        <= busy_d;
        end
    end

    assign outNibble      = nibble_q;
    assign outNibbleValid = nibbleValid_q;
    assign outFrameStart  = frameStart_q;
    assign outFrameEnd    = frameEnd_q;
    assign outLength      = length_q;
    assign outSyncError   = syncErr_q;
    assign outLengthError = lenErr_q;
    assign outAbort       = abort_q;
    assign outBusy        = busy_q;

endmodule
`default_nettype wire

// File: doc/rx_phy_deframer.md
Name: rx_phy_deframer

Overview:
- Receive-side counterpart of the transmit framing: drains the 4-bit receive FIFO that collects CDR-recovered bits.
- Locates the 802.15.4 synchronisation header (preamble plus SFD 0xA7) and extracts the 7-bit PHR frame length.
- Delivers the payload as a qualified nibble stream with start/end markers.
- Reports sync, length and timeout errors.

Parameters:
- PREAMBLE_NIBBLES, 8: number of consecutive 0x0 nibbles required before an SFD is accepted.
- MAX_LEN, 127: largest legal PHR length in bytes.
- TIMEOUT_CYCLES, 1024: cycles without a received nibble, outside HUNT, before the frame is aborted.

Ports:
- inClock  in  1  system clock.
- inReset  in  1  asynchronous, active-high reset.
- inEnable  in  1  when low, no new FIFO reads are issued.
- inEmpty  in  1  receive FIFO empty flag.
- inData  in  4  receive FIFO read data, valid one cycle after outReadEnable.
- outReadEnable  out  1  FIFO read strobe.
- outNibble  out  4  payload nibble.
- outNibbleValid  out  1  outNibble qualifier, one-cycle pulse per nibble.
- outFrameStart  out  1  pulse coincident with the first payload nibble.
- outFrameEnd  out  1  pulse coincident with the last payload nibble.
- outLength  out  7  PHR length of the current or last frame, in bytes.
- outSyncError  out  1  pulse on bad SFD nibble.
- outLengthError  out  1  pulse on illegal PHR length.
- outAbort  out  1  pulse on timeout.
- outBusy  out  1  high in any state except HUNT.

Behaviour:
- Reset (asynchronous, active-high): state=HUNT, zero counter=0, timeout counter=0, rdPending=0. All outputs are 0, including outNibble and outLength.
- Read handshake:
  - outReadEnable = inEnable & ~inEmpty & ~inReset (combinational).
  - rdPending is outReadEnable registered. Back-to-back reads are allowed.
  - A nibble is consumed in the cycle rdPending=1, sampling inData.
  - A read already in flight when inEnable falls is still consumed.
  - Reads are never issued while inEmpty=1.
- Nibble order on the wire: SFD low nibble 0x7 first, then 0xA. PHR low nibble first, then high nibble. PHR bit 7 is ignored.
- State machine (transitions occur only on a consumed nibble unless stated otherwise):
  - HUNT: 0x0 increments the zero counter, saturating at PREAMBLE_NIBBLES. Any other nibble clears the counter. When the counter reaches PREAMBLE_NIBBLES, go to SFD_LO.
  - SFD_LO: 0x0 stays (extra preamble tolerated). 0x7 goes to SFD_HI. Anything else pulses outSyncError and goes to HUNT with counter=0.
  - SFD_HI: 0xA goes to LEN_LO. Anything else pulses outSyncError and goes to HUNT with counter=0.
  - LEN_LO: store the low nibble, go to LEN_HI.
  - LEN_HI: compute len = {nibble[2:0], low}.
    - len=0 or len>MAX_LEN: pulse outLengthError, go to HUNT. outLength is unchanged.
    - Otherwise: load outLength=len and a remaining-nibble counter=2*len (8 bits), go to PAYLOAD.
  - PAYLOAD: each consumed nibble appears on outNibble, with outNibbleValid=1 in the following cycle (latency 1 from rdPending). The counter decrements per nibble.
    - outFrameStart is high with the first payload nibble.
    - outFrameEnd is high with the nibble for which the counter is 1; the state then returns to HUNT with counter=0.
    - For len=1, outFrameEnd falls on the second nibble.
- Timeout:
  - In every state except HUNT, the timeout counter increments each cycle with no consumed nibble and clears on each consumed nibble.
  - On reaching TIMEOUT_CYCLES: pulse outAbort, go to HUNT, clear all counters. No outFrameEnd is issued.
- An error or abort pulse is one cycle wide and is never coincident with outNibbleValid.
- inReset asserted mid-frame clears state immediately. No outFrameEnd or outAbort is emitted.
- outBusy = (state != HUNT), registered.

Test Plan:
- Nibbles 0×8, 7, A, 3, 0, then 6 payload nibbles 1..6, back-to-back -> outFrameStart with nibble 1, outFrameEnd with nibble 6, outLength=3, exactly 6 outNibbleValid pulses, outBusy falls the cycle after the end.
- Preamble of 12 zeros, then 7, A, len=1 (nibbles 1, 0), payload F, E -> frame accepted, outFrameStart on F, outFrameEnd on E.
- 0×8, 7, 5 -> outSyncError pulse one cycle after 5 is consumed. A following valid frame is then received correctly.
- PHR 0x00 and PHR 0x80 (nibbles 0, 8) -> outLengthError each time, outLength keeps its previous value, no outNibbleValid.
- Valid header with len=4, supply 3 payload nibbles, then inEmpty=1 for 1024 cycles -> outAbort pulse, no outFrameEnd, outBusy=0.
- inEmpty toggling every other cycle with inEnable low for 5 cycles mid-payload -> outReadEnable is never high while inEmpty or ~inEnable, and the nibble sequence arrives intact. Assert inReset mid-payload -> all outputs 0 immediately.
